// File: rtl/intr_ctrl_if.sv
// Software/CPU-facing bus of the interrupt controller: mask and pending-clear
// writes plus the INTR / INTR_ACK / INTR_DONE request handshake.
interface intr_ctrl_if #(
    parameter int N_SRC = 8,
    parameter int IDW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    logic             MASK_WE;
    logic [N_SRC-1:0] MASK_WDATA;
    logic             PCLR_WE;
    logic [N_SRC-1:0] PCLR_WDATA;
    logic             INTR;
    logic [IDW-1:0]   INTR_ID;
    logic             INTR_ACK;
    logic             INTR_DONE;

    // master = CPU / register-bus side, slave = interrupt controller
    modport master (
        output MASK_WE, MASK_WDATA, PCLR_WE, PCLR_WDATA, INTR_ACK, INTR_DONE,
        input  INTR, INTR_ID
    );

    modport slave (
        input  MASK_WE, MASK_WDATA, PCLR_WE, PCLR_WDATA, INTR_ACK, INTR_DONE,
        output INTR, INTR_ID
    );
endinterface

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: synchronises N async lines, latches rising
// edges as pending bits, masks them and offers one fixed-priority request at a time.
module intr_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic [N_SRC-1:0] MASK,
    output logic [N_SRC-1:0] PENDING,
    intr_ctrl_if.slave       bus
);
    localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] hist_q;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] sw_clr;
    logic [N_SRC-1:0] ack_clr;

    logic [IDW-1:0]   winner;
    logic             any_eligible;

    state_t           state_q, state_d;
    logic             intr_q, intr_d;
    logic [IDW-1:0]   id_q, id_d;

    // NOTE: the synchroniser array is cleared on reset so a line already high at
    // release is seen as exactly one rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            hist_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value
            // of the previous stage, which is what turns this into a shift chain.
            sync_q[0] <= IRQ_IN;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign eligible = pend_q & mask_q;

    // Lowest set index wins; scan from the top so the last hit is the lowest.
    always_comb begin
        winner       = '0;
        any_eligible = |eligible;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            intr_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        intr_d  = intr_q;
        id_d    = id_q;
        ack_clr = '0;

        unique case (state_q)
            S_IDLE: begin
                if (any_eligible) begin
                    state_d = S_REQ;
                    intr_d  = 1'b1;
                    id_d    = winner;
                end
            end
            S_REQ: begin
                // ACK beats withdraw when both happen in the same cycle.
                if (bus.INTR_ACK) begin
                    ack_clr = N_SRC'(1) << id_q;
                    intr_d  = 1'b0;
                    state_d = S_SERVICE;
                end else if (!eligible[id_q]) begin
                    intr_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                intr_d = 1'b0;
                if (bus.INTR_DONE) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    // A new edge wins over a software or ACK clear of the same bit.
    assign sw_clr = bus.PCLR_WE ? bus.PCLR_WDATA : '0;
    assign pend_d = (pend_q & ~(sw_clr | ack_clr)) | rise;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.MASK_WE) mask_q <= bus.MASK_WDATA;
        end
    end

    assign MASK        = mask_q;
    assign PENDING     = pend_q;
    assign bus.INTR    = intr_q;
    assign bus.INTR_ID = id_q;
endmodule
